bank_accounter: RTL and testbench

Upstream bookkeeping stage for the read path of the multi-bank RAM. Each write agent owns one BRAM bank. This block records, per address, which bank holds the most recent write and whether that write collided with another agent. Each cycle it returns that record for every read agent's address as `bank_select`, the selector the read switch uses to route bank addresses and data.

---
 rtl/meduram_pkg.sv | 32 +++
 rtl/bank_accounter_write_resolver.sv | 34 +++
 rtl/bank_accounter.sv | 104 ++++++++++
 tb/tb_bank_accounter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-bank RAM: selector sizing, statistics width
// and selector field packing used by both the bank accounter and the read switch.
package meduram_pkg;

    localparam int unsigned STAT_WIDTH = 16;

    function automatic int unsigned select_width(input int unsigned nb_wragent,
                                                 input int unsigned write_collision);
        return ((nb_wragent == 1) ? 1 : $clog2(nb_wragent)) + write_collision;
    endfunction

    function automatic int unsigned select_range(input int unsigned nb_wragent,
                                                 input int unsigned write_collision);
        return select_width(nb_wragent, write_collision) - write_collision;
    endfunction

    // Callers slice the low select_width bits; the flag lands just above the bank id.
    function automatic logic [31:0] pack_select(input int unsigned sel_range,
                                                input logic        coll,
                                                input int unsigned bank);
        logic [31:0] sel;
        sel            = 32'(bank);
        sel[sel_range] = coll;
        return sel;
    endfunction

    function automatic logic select_collision(input logic [31:0] sel,
                                              input int unsigned sel_range);
        return sel[sel_range];
    endfunction

endpackage

// File: rtl/bank_accounter_write_resolver.sv
// Per-cycle write arbitration: highest-index agent wins a shared address and
// every agent sharing an address with another enabled agent is flagged collided.
module write_resolver #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NB_WRAGENT = 2
) (
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    output logic [NB_WRAGENT-1:0]            winner,
    output logic [NB_WRAGENT-1:0]            collided,
    output logic                             any_collision
);

    always_comb begin
        winner   = '0;
        collided = '0;
        for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
            if (wren[i]) begin
                winner[i] = 1'b1;
                for (int unsigned j = 0; j < NB_WRAGENT; j++) begin
                    if (j != i && wren[j] &&
                        wraddr[j*ADDR_WIDTH +: ADDR_WIDTH] == wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        collided[i] = 1'b1;
                        if (j > i) begin
                            winner[i] = 1'b0;
                        end
                    end
                end
            end
        end
        any_collision = |collided;
    end

endmodule

// File: rtl/bank_accounter.sv
// Per-address record of the bank holding the latest write (plus collision flag),
// read combinationally per read agent. Optional counter: BANK_ACCOUNTER_STATS_EN.
module bank_accounter
    import meduram_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH      = 8,
    parameter int unsigned  NB_WRAGENT      = 2,
    parameter int unsigned  NB_RDAGENT      = 2,
    parameter int unsigned  WRITE_COLLISION = 1,
    localparam int unsigned SELECT_WIDTH    = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_RDAGENT-1:0]            rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
    input  logic                             stat_clear,
    output logic [STAT_WIDTH-1:0]            stat_wrcoll
);

    localparam int unsigned SELECT_RANGE = select_range(NB_WRAGENT, WRITE_COLLISION);
    localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;

    logic [NB_WRAGENT-1:0]   winner;
    logic [NB_WRAGENT-1:0]   collided;
    logic                    any_collision;
    logic [SELECT_WIDTH-1:0] table_q [DEPTH];
    logic [SELECT_WIDTH-1:0] table_d [DEPTH];
    logic [31:0]             sel;
    logic                    unused_inputs;

    write_resolver #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WRAGENT (NB_WRAGENT)
    ) u_write_resolver (
        .wren          (wren),
        .wraddr        (wraddr),
        .winner        (winner),
        .collided      (collided),
        .any_collision (any_collision)
    );

    // Winners always target distinct addresses, so update order is irrelevant.
    always_comb begin
        table_d = table_q;
        sel     = '0;
        for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
            if (winner[i]) begin
                sel = pack_select(SELECT_RANGE,
                                  (WRITE_COLLISION != 0) && collided[i],
                                  (NB_WRAGENT == 1) ? 0 : i);
                table_d[wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = sel[SELECT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                table_q[a] <= '0;
            end
        end else begin
            table_q <= table_d;
        end
    end

    always_comb begin
        bank_select = '0;
        for (int unsigned r = 0; r < NB_RDAGENT; r++) begin
            bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = table_q[rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

`ifdef BANK_ACCOUNTER_STATS_EN
    logic [STAT_WIDTH-1:0] stat_wrcoll_q;
    logic [STAT_WIDTH-1:0] stat_wrcoll_d;

    always_comb begin
        stat_wrcoll_d = stat_wrcoll_q;
        if (stat_clear) begin
            stat_wrcoll_d = '0;
        end else if (any_collision && stat_wrcoll_q != '1) begin
            stat_wrcoll_d = stat_wrcoll_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_wrcoll_q <= '0;
        end else begin
            stat_wrcoll_q <= stat_wrcoll_d;
        end
    end

    assign stat_wrcoll   = stat_wrcoll_q;
    assign unused_inputs = ^rden;
`else
    assign stat_wrcoll   = '0;
    assign unused_inputs = ^{rden, stat_clear, any_collision};
`endif

endmodule

// File: tb/tb_bank_accounter.sv
// Randomized + directed bench for bank_accounter against a per-address
// reference model of last writer and collision flag.
module tb_bank_accounter;

`ifdef BANK_ACCOUNTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  wren;
    logic [15:0] wraddr;
    logic [1:0]  rden;
    logic [15:0] rdaddr;
    logic [3:0]  bank_select;
    logic        stat_clear;
    logic [15:0] stat_wrcoll;

    int n_checks = 0;
    int n_fail   = 0;

    int m_bank [256];
    int m_flag [256];
    int m_stat;

    bank_accounter #(
        .ADDR_WIDTH      (8),
        .NB_WRAGENT      (2),
        .NB_RDAGENT      (2),
        .WRITE_COLLISION (1)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .wren        (wren),
        .wraddr      (wraddr),
        .rden        (rden),
        .rdaddr      (rdaddr),
        .bank_select (bank_select),
        .stat_clear  (stat_clear),
        .stat_wrcoll (stat_wrcoll)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) begin
            m_bank[a] = 0;
            m_flag[a] = 0;
        end
        m_stat = 0;
    endtask

    // Drive one cycle, check outputs against the pre-edge model, then apply the edge.
    task automatic step(input logic [1:0] we, input logic [7:0] wa0, input logic [7:0] wa1,
                        input logic [1:0] re, input logic [7:0] ra0, input logic [7:0] ra1,
                        input logic clr);
        int cnt  [int];
        int last [int];
        bit anyc;
        int a;
        wren = we; wraddr = {wa1, wa0}; rden = re; rdaddr = {ra1, ra0}; stat_clear = clr;
        @(negedge aclk);
        check("rd0", 32'(bank_select[1:0]), 32'((m_flag[ra0] << 1) | m_bank[ra0]));
        check("rd1", 32'(bank_select[3:2]), 32'((m_flag[ra1] << 1) | m_bank[ra1]));
        check("stat", 32'(stat_wrcoll), 32'(m_stat));
        anyc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (we[i]) begin
                a = (i == 1) ? int'(wa1) : int'(wa0);
                if (cnt.exists(a)) cnt[a] = cnt[a] + 1;
                else cnt[a] = 1;
                last[a] = i;
            end
        end
        foreach (cnt[k]) begin
            m_bank[k] = last[k];
            m_flag[k] = (cnt[k] > 1) ? 1 : 0;
            if (cnt[k] > 1) anyc = 1'b1;
        end
        if (STATS) begin
            if (clr) m_stat = 0;
            else if (anyc && m_stat < 65535) m_stat = m_stat + 1;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic probe(input logic [7:0] ra0, input logic [7:0] ra1, input logic [1:0] e0,
                         input logic [1:0] e1, input logic [15:0] estat, input string tag);
        wren = 2'b00; stat_clear = 1'b0; rden = 2'b11; rdaddr = {ra1, ra0};
        @(negedge aclk);
        check({tag, "_rd0"}, 32'(bank_select[1:0]), 32'(e0));
        check({tag, "_rd1"}, 32'(bank_select[3:2]), 32'(e1));
        check({tag, "_stat"}, 32'(stat_wrcoll), 32'(estat));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0; wren = '0; wraddr = '0; rden = '0; rdaddr = '0; stat_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        probe(8'h00, 8'hFF, 2'b00, 2'b00, 16'd0, "reset");

        step(2'b10, 8'h00, 8'h10, 2'b01, 8'h10, 8'h10, 1'b0);
        probe(8'h10, 8'h10, 2'b01, 2'b01, 16'd0, "wr_a1");

        step(2'b11, 8'h20, 8'h20, 2'b00, 8'h20, 8'h00, 1'b0);
        probe(8'h20, 8'h20, 2'b11, 2'b11, STATS ? 16'd1 : 16'd0, "coll");
        step(2'b01, 8'h20, 8'h77, 2'b00, 8'h20, 8'h20, 1'b0);
        probe(8'h20, 8'h20, 2'b00, 2'b00, STATS ? 16'd1 : 16'd0, "flag_clr");

        step(2'b11, 8'h30, 8'h31, 2'b00, 8'h30, 8'h31, 1'b0);
        probe(8'h30, 8'h31, 2'b00, 2'b01, STATS ? 16'd1 : 16'd0, "indep");

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a0, a1, r0, r1;
            a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            step(2'($urandom), a0, a1, 2'($urandom), r0, r1, ($urandom_range(0, 15) == 0));
        end

`ifdef BANK_ACCOUNTER_STATS_EN
        for (int n = 0; n < 65540; n++) begin
            step(2'b11, 8'h50, 8'h50, 2'b00, 8'h50, 8'h51, 1'b0);
        end
        probe(8'h50, 8'h50, 2'b11, 2'b11, 16'hFFFF, "sat");
        step(2'b11, 8'h52, 8'h52, 2'b00, 8'h52, 8'h50, 1'b1);
        probe(8'h52, 8'h52, 2'b11, 2'b11, 16'd0, "clear");
`endif

        step(2'b10, 8'h00, 8'h40, 2'b00, 8'h40, 8'h40, 1'b0);
        wren = 2'b00; stat_clear = 1'b0; rdaddr = {8'h40, 8'h40};
        @(negedge aclk);
        check("pre_rst", 32'(bank_select), 32'h5);
        aresetn = 1'b0;
        #1;
        check("async_rst", 32'(bank_select), 32'h0);
        check("async_rst_stat", 32'(stat_wrcoll), 32'h0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        probe(8'h40, 8'h40, 2'b00, 2'b00, 16'd0, "post_rst");
        step(2'b01, 8'h41, 8'h00, 2'b00, 8'h40, 8'h41, 1'b0);
        probe(8'h41, 8'h40, 2'b00, 2'b00, 16'd0, "post_rst_wr");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
